// File: rtl/noc_credit_rx_port.sv
// Receive end of a valid/yummy credit NoC channel: flit FIFO, credit return,
// and header-length packet framing presented over ready/valid.
module noc_credit_rx_port #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned LEN_LSB    = 22
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    noc_valid,
    input  logic [DATA_WIDTH-1:0]   noc_data,
    output logic                    noc_yummy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_sop,
    output logic                    out_eop,
    output logic [7:0]              out_len,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {
        HDR,
        BODY
    } trk_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic                  valid_r;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic [DATA_WIDTH-1:0] head;
    logic [7:0]            head_len;
    trk_state_t            state;
    logic [7:0]            len_r;
    logic [7:0]            remaining;

    // A push into a full FIFO is only legal when a pop frees the slot this cycle.
    always_comb begin
        full       = (count == CW'(DEPTH));
        pop        = valid_r && out_ready;
        push       = noc_valid && (!full || pop);
        drop       = noc_valid && full && !pop;
        count_next = count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            valid_r   <= 1'b0;
            noc_yummy <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count     <= count_next;
            valid_r   <= (count_next != '0);
            noc_yummy <= pop;
            if (drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= noc_data;
    end

    assign head       = mem[rd_ptr];
    assign head_len   = head[LEN_LSB +: 8];
    assign out_data   = head;
    assign out_valid  = valid_r;
    assign fifo_count = count;
    assign out_sop    = (state == HDR);

    // Framing annotation; masked while empty so stale storage never shows.
    always_comb begin
        out_eop = 1'b0;
        out_len = len_r;
        if (state == HDR) begin
            out_len = valid_r ? head_len : 8'd0;
            out_eop = valid_r && (head_len == 8'd0);
        end else begin
            out_eop = valid_r && (remaining == 8'd1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= HDR;
            len_r     <= 8'd0;
            remaining <= 8'd0;
        end else if (pop) begin
            case (state)
                HDR: begin
                    if (head_len != 8'd0) begin
                        len_r     <= head_len;
                        remaining <= head_len;
                        state     <= BODY;
                    end
                end
                BODY: begin
                    remaining <= remaining - 8'd1;
                    if (remaining == 8'd1) state <= HDR;
                end
                default: state <= HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_credit_rx_port.sv
// Randomised and directed bench for noc_credit_rx_port against a queue-based
// model of the FIFO, credit return and packet framing.
module tb_noc_credit_rx_port;

    localparam int DW      = 64;
    localparam int DEPTH   = 4;
    localparam int LEN_LSB = 22;

    logic          clock;
    logic          reset;
    logic          noc_valid;
    logic [DW-1:0] noc_data;
    logic          noc_yummy;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_sop;
    logic          out_eop;
    logic [7:0]    out_len;
    logic [2:0]    fifo_count;
    logic          overflow;

    noc_credit_rx_port #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LEN_LSB(LEN_LSB)) dut (
        .clock(clock), .reset(reset),
        .noc_valid(noc_valid), .noc_data(noc_data), .noc_yummy(noc_yummy),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .out_len(out_len),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: queued flits, position within current packet, sticky error.
    logic [DW-1:0] q[$];
    int            pos;
    int            cur_len;
    bit            exp_yummy;
    bit            m_ovf;
    int            n_yummy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        pos       = 0;
        cur_len   = 0;
        exp_yummy = 1'b0;
        m_ovf     = 1'b0;
    endtask

    task automatic check_all();
        int l;
        chkb("out_valid", out_valid, q.size() != 0);
        chk("fifo_count", 64'(fifo_count), 64'(q.size()));
        chkb("noc_yummy", noc_yummy, exp_yummy);
        chkb("overflow", overflow, m_ovf);
        chkb("out_sop", out_sop, pos == 0);
        if (q.size() != 0) begin
            chk("out_data", out_data, q[0]);
            if (pos == 0) begin
                l = int'(q[0][LEN_LSB +: 8]);
                chk("out_len_hdr", 64'(out_len), 64'(l));
                chkb("out_eop_hdr", out_eop, l == 0);
            end else begin
                chk("out_len_body", 64'(out_len), 64'(cur_len));
                chkb("out_eop_body", out_eop, pos == cur_len);
            end
        end else begin
            chkb("out_eop_empty", out_eop, 1'b0);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare at the negedge.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit r);
        bit            pop;
        bit            full;
        bit            stall;
        logic [DW-1:0] prev;
        int            l;
        noc_valid = v;
        noc_data  = d;
        out_ready = r;
        pop   = (q.size() != 0) && r;
        full  = (q.size() == DEPTH);
        stall = (q.size() != 0) && !r;
        prev  = out_data;
        if (pop) begin
            if (pos == 0) begin
                l = int'(q[0][LEN_LSB +: 8]);
                if (l != 0) begin
                    cur_len = l;
                    pos     = 1;
                end
            end else if (pos == cur_len) begin
                pos = 0;
            end else begin
                pos++;
            end
            void'(q.pop_front());
        end
        if (v) begin
            if (!full || pop) q.push_back(d);
            else m_ovf = 1'b1;
        end
        exp_yummy = pop;
        @(posedge clock);
        @(negedge clock);
        if (noc_yummy) n_yummy++;
        if (stall) chk("stall_hold", out_data, prev);
        check_all();
    endtask

    // Asynchronous reset asserted mid-cycle, checked before any clock edge.
    task automatic do_reset();
        noc_valid = 1'b0;
        out_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chkb("rst_out_valid", out_valid, 1'b0);
        chk("rst_fifo_count", 64'(fifo_count), 64'd0);
        chkb("rst_out_sop", out_sop, 1'b1);
        chkb("rst_noc_yummy", noc_yummy, 1'b0);
        chkb("rst_overflow", overflow, 1'b0);
        model_clear();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_all();
    endtask

    function automatic logic [DW-1:0] mk_hdr(input int l);
        logic [DW-1:0] h;
        h = {$urandom, $urandom};
        h[LEN_LSB +: 8] = 8'(l);
        return h;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] stream[$];
        int            total;
        int            y;
        int            budget;
        bit            v;
        bit            r;
        logic [DW-1:0] d;

        reset     = 1'b1;
        noc_valid = 1'b0;
        noc_data  = '0;
        out_ready = 1'b0;
        n_yummy   = 0;
        model_clear();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chkb("reset_valid", out_valid, 1'b0);
        chkb("reset_yummy", noc_yummy, 1'b0);
        chkb("reset_sop", out_sop, 1'b1);
        chkb("reset_eop", out_eop, 1'b0);
        chk("reset_len", 64'(out_len), 64'd0);
        chk("reset_count", 64'(fifo_count), 64'd0);
        chkb("reset_ovf", overflow, 1'b0);
        check_all();

        // Single zero-length header.
        step(0, '0, 0);
        step(0, '0, 0);
        step(1, 64'h0, 1);
        chkb("single_valid", out_valid, 1'b1);
        chkb("single_sop", out_sop, 1'b1);
        chkb("single_eop", out_eop, 1'b1);
        step(0, '0, 1);
        chkb("single_yummy", noc_yummy, 1'b1);
        chk("single_count", 64'(fifo_count), 64'd0);
        step(0, '0, 1);
        chkb("single_yummy_once", noc_yummy, 1'b0);

        // Three-flit packet.
        step(1, 64'(2) << LEN_LSB, 1);
        chkb("p3_sop0", out_sop, 1'b1);
        chkb("p3_eop0", out_eop, 1'b0);
        chk("p3_len0", 64'(out_len), 64'd2);
        step(1, 64'hA, 1);
        chkb("p3_y0", noc_yummy, 1'b1);
        chkb("p3_sop1", out_sop, 1'b0);
        chkb("p3_eop1", out_eop, 1'b0);
        chk("p3_len1", 64'(out_len), 64'd2);
        chk("p3_data1", out_data, 64'hA);
        step(1, 64'hB, 1);
        chkb("p3_y1", noc_yummy, 1'b1);
        chkb("p3_eop2", out_eop, 1'b1);
        chk("p3_len2", 64'(out_len), 64'd2);
        step(0, '0, 1);
        chkb("p3_y2", noc_yummy, 1'b1);
        chkb("p3_sop_after", out_sop, 1'b1);

        // Overflow with stalled consumer.
        for (int i = 1; i <= 4; i++) step(1, 64'(i), 0);
        chk("ovf_count_full", 64'(fifo_count), 64'd4);
        chkb("ovf_clear", overflow, 1'b0);
        step(1, 64'h5, 0);
        chk("ovf_count_drop", 64'(fifo_count), 64'd4);
        chkb("ovf_set", overflow, 1'b1);
        y = 0;
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_drain_data", out_data, 64'(i));
            step(0, '0, 1);
            y += int'(noc_yummy);
        end
        chk("ovf_drain_yummies", 64'(y), 64'd4);
        chk("ovf_drain_count", 64'(fifo_count), 64'd0);
        step(0, '0, 0);
        chkb("ovf_sticky", overflow, 1'b1);
        do_reset();

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 4; i++) step(1, 64'h10 + 64'(i), 0);
        step(1, 64'h14, 1);
        chk("fullpp_count", 64'(fifo_count), 64'd4);
        chkb("fullpp_ovf", overflow, 1'b0);
        chkb("fullpp_yummy", noc_yummy, 1'b1);
        chk("fullpp_head", out_data, 64'h11);
        for (int i = 0; i < 5; i++) step(0, '0, 1);
        step(0, '0, 0);

        // Randomised packets with stalls.
        total = 0;
        for (int p = 0; p < 100; p++) begin
            int l;
            l = int'($urandom_range(0, 8));
            stream.push_back(mk_hdr(l));
            for (int b = 0; b < l; b++) stream.push_back({$urandom, $urandom});
            total += l + 1;
        end
        n_yummy = 0;
        budget  = 0;
        while (stream.size() != 0 && budget < 20000) begin
            v = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 9) < 6);
            if (q.size() == DEPTH && !r) v = 1'b0;
            d = {$urandom, $urandom};
            if (v) d = stream.pop_front();
            step(v, d, r);
            budget++;
        end
        chk("rand_stream_done", 64'(stream.size()), 64'd0);
        budget = 0;
        while (q.size() != 0 && budget < 64) begin
            step(0, '0, 1);
            budget++;
        end
        step(0, '0, 0);
        chk("rand_drained", 64'(q.size()), 64'd0);
        chk("rand_yummy_total", 64'(n_yummy), 64'(total));

        // Reset with two flits buffered mid-body and a yummy pending.
        step(1, 64'(5) << LEN_LSB, 0);
        step(1, 64'hB1, 1);
        step(1, 64'hB2, 0);
        step(1, 64'hB3, 1);
        chk("mid_count", 64'(fifo_count), 64'd2);
        chkb("mid_sop", out_sop, 1'b0);
        chkb("mid_yummy", noc_yummy, 1'b1);
        do_reset();
        step(1, 64'(3) << LEN_LSB, 0);
        chkb("post_rst_sop", out_sop, 1'b1);
        chk("post_rst_len", 64'(out_len), 64'd3);
        chkb("post_rst_eop", out_eop, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
